// File: rtl/echo_voice_arb_pkg.sv
// rtl/echo_voice_arb_pkg.sv - shared note event types and constants for the echo voice arbiter
package echo_pkg;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic [8:0] pb;
    logic [1:0] cc1;
  } note_evt_t;

  localparam logic [8:0] PB_CENTER = 9'd256;

  // Value every change detector and the channel payload start from
  localparam note_evt_t EVT_RESET = '{on: 1'b0, note: 7'd0, vel: 7'd0, pb: PB_CENTER, cc1: 2'd0};

  typedef enum logic [1:0] {OWN_NONE, OWN_LIVE, OWN_ECHO} owner_t;

  typedef enum logic {ST_IDLE, ST_SEND} arb_state_t;

endpackage

// File: rtl/echo_voice_arb_if.sv
// rtl/echo_voice_arb_if.sv - live/echo note bundles in, single voice trigger channel out
interface echo_voice_arb_if;

  logic       en;
  logic       live_on;
  logic [6:0] live_note;
  logic [6:0] live_vel;
  logic [8:0] live_pb;
  logic [1:0] live_cc1;
  logic       echo_on;
  logic [6:0] echo_note;
  logic [6:0] echo_vel;
  logic [8:0] echo_pb;
  logic [1:0] echo_cc1;
  logic       ch_ready;
  logic       ch_trig;
  logic       ch_on;
  logic [6:0] ch_note;
  logic [6:0] ch_vel;
  logic [8:0] ch_pb;
  logic [1:0] ch_cc1;
  logic       ch_src;
  logic       echo_drop;

  // master: the arbiter; slave: the sources and channel writer around it
  modport master (
    input  en, live_on, live_note, live_vel, live_pb, live_cc1,
    input  echo_on, echo_note, echo_vel, echo_pb, echo_cc1, ch_ready,
    output ch_trig, ch_on, ch_note, ch_vel, ch_pb, ch_cc1, ch_src, echo_drop
  );

  modport slave (
    output en, live_on, live_note, live_vel, live_pb, live_cc1,
    output echo_on, echo_note, echo_vel, echo_pb, echo_cc1, ch_ready,
    input  ch_trig, ch_on, ch_note, ch_vel, ch_pb, ch_cc1, ch_src, echo_drop
  );

endinterface

// File: rtl/echo_voice_arb_fifo.sv
// rtl/echo_voice_arb_fifo.sv - synchronous FIFO of echo note events with show-ahead head
module note_evt_fifo
  import echo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  note_evt_t wdata,
  output note_evt_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  note_evt_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer bit separates full from empty when the indices coincide
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/echo_voice_arb.sv
// rtl/echo_voice_arb.sv - change-detects live and echo bundles and arbitrates them onto one voice channel
module echo_voice_arb
  import echo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  echo_voice_arb_if.master bus
);

  note_evt_t  live_in, echo_in;
  note_evt_t  live_cap, echo_cap;
  note_evt_t  ch_evt, head;
  arb_state_t state;
  owner_t     owner;
  logic       pending;
  logic       src_q;
  logic       drop_q;
  logic       live_chg, echo_chg;
  logic       full, empty, push, pop;
  logic       echo_ok;

  assign live_in = '{on: bus.live_on, note: bus.live_note, vel: bus.live_vel,
                     pb: bus.live_pb, cc1: bus.live_cc1};
  assign echo_in = '{on: bus.echo_on, note: bus.echo_note, vel: bus.echo_vel,
                     pb: bus.echo_pb, cc1: bus.echo_cc1};

  assign live_chg = bus.en && (live_in != live_cap);
  assign echo_chg = bus.en && (echo_in != echo_cap);

  // The echo queue is only serviced when no live event is waiting
  assign pop  = bus.en && (state == ST_IDLE) && !pending && !empty;
  assign push = echo_chg && (!full || pop);

  // Echo note-offs may only release a note the echo source itself is sounding
  assign echo_ok = (owner != OWN_LIVE) &&
                   (head.on || ((owner == OWN_ECHO) && (head.note == ch_evt.note)));

  note_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (echo_in),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_cap <= EVT_RESET;
      echo_cap <= EVT_RESET;
    end else begin
      if (live_chg) live_cap <= live_in;
      if (echo_chg) echo_cap <= echo_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= OWN_NONE;
      ch_evt  <= EVT_RESET;
      src_q   <= 1'b0;
      pending <= 1'b0;
      drop_q  <= 1'b0;
    end else if (!bus.en) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= (echo_chg && full && !pop) || (pop && !echo_ok);
      // A fresh capture wins over the slot being taken, so it is never lost
      pending <= live_chg || (pending && !(state == ST_IDLE));
      case (state)
        ST_IDLE: begin
          if (pending) begin
            ch_evt <= live_cap;
            src_q  <= 1'b0;
            state  <= ST_SEND;
          end else if (!empty && echo_ok) begin
            ch_evt <= head;
            src_q  <= 1'b1;
            state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.ch_ready) begin
            state <= ST_IDLE;
            if (ch_evt.on) owner <= src_q ? OWN_ECHO : OWN_LIVE;
            else           owner <= OWN_NONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ch_trig   = bus.en && (state == ST_SEND);
  assign bus.ch_on     = ch_evt.on;
  assign bus.ch_note   = ch_evt.note;
  assign bus.ch_vel    = ch_evt.vel;
  assign bus.ch_pb     = ch_evt.pb;
  assign bus.ch_cc1    = ch_evt.cc1;
  assign bus.ch_src    = src_q;
  assign bus.echo_drop = drop_q;

endmodule

// File: tb/tb_echo_voice_arb.sv
// tb/tb_echo_voice_arb.sv - scenario tests plus randomized run against an event-level model
module tb_echo_voice_arb;
  import echo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   drops = 0;

  typedef struct {
    note_evt_t evt;
    logic      src;
    int        cyc;
  } xfer_t;

  xfer_t xq[$];

  echo_voice_arb_if bus();

  echo_voice_arb #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!reset && bus.ch_trig && bus.ch_ready) begin
      xfer_t x;
      x.evt = '{on: bus.ch_on, note: bus.ch_note, vel: bus.ch_vel, pb: bus.ch_pb, cc1: bus.ch_cc1};
      x.src = bus.ch_src;
      x.cyc = cyc;
      xq.push_back(x);
    end
    if (!reset && bus.echo_drop) drops++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_live(input note_evt_t e);
    {bus.live_on, bus.live_note, bus.live_vel, bus.live_pb, bus.live_cc1} = e;
  endtask

  task automatic drive_echo(input note_evt_t e);
    {bus.echo_on, bus.echo_note, bus.echo_vel, bus.echo_pb, bus.echo_cc1} = e;
  endtask

  function automatic note_evt_t mk(input logic on, input int note, input int vel);
    mk = '{on: on, note: 7'(note), vel: 7'(vel), pb: PB_CENTER, cc1: 2'd0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.en = 1'b1;
    bus.ch_ready = 1'b1;
    drive_live(EVT_RESET);
    drive_echo(EVT_RESET);
    step(3);
    checks++; if (bus.ch_trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %0b want 0", bus.ch_trig); end
    checks++; if (bus.ch_pb !== 9'd256) begin errors++; $display("FAIL reset_pb got %0d want 256", bus.ch_pb); end
    checks++; if ({bus.ch_on, bus.ch_note, bus.ch_vel, bus.ch_cc1, bus.ch_src, bus.echo_drop} !== '0) begin
      errors++; $display("FAIL reset_payload got on%0b n%0d v%0d c%0d s%0b d%0b want zeros",
                         bus.ch_on, bus.ch_note, bus.ch_vel, bus.ch_cc1, bus.ch_src, bus.echo_drop);
    end
    reset = 1'b0;
    step(3);
    checks++; if (xq.size() !== 0) begin errors++; $display("FAIL reset_idle got %0d xfers want 0", xq.size()); end
  endtask

  task automatic test_live_basic();
    xq.delete();
    drive_live(mk(1, 60, 100));
    step(1);
    checks++; if (bus.ch_trig !== 1'b0) begin errors++; $display("FAIL live_lat1 got trig %0b want 0", bus.ch_trig); end
    step(1);
    checks++; if ({bus.ch_trig, bus.ch_note, bus.ch_vel, bus.ch_src} !== {1'b1, 7'd60, 7'd100, 1'b0}) begin
      errors++; $display("FAIL live_issue got t%0b n%0d v%0d s%0b want t1 n60 v100 s0",
                         bus.ch_trig, bus.ch_note, bus.ch_vel, bus.ch_src);
    end
    step(1);
    checks++; if (xq.size() !== 1 || bus.ch_trig !== 1'b0) begin
      errors++; $display("FAIL live_accept got %0d xfers trig %0b want 1 and 0", xq.size(), bus.ch_trig);
    end
  endtask

  task automatic test_echo_blocked();
    int d0;
    xq.delete();
    d0 = drops;
    drive_echo(mk(1, 64, 50));
    step(5);
    checks++; if (drops - d0 !== 1 || xq.size() !== 0) begin
      errors++; $display("FAIL echo_blocked got drops %0d xfers %0d want 1 and 0", drops - d0, xq.size());
    end
    drive_live(mk(0, 60, 100));
    step(5);
    checks++; if (xq.size() !== 1 || xq[0].src !== 1'b0 || xq[0].evt.on !== 1'b0) begin
      errors++; $display("FAIL live_off got %0d xfers want 1 live off", xq.size());
    end
    drive_echo(mk(1, 67, 50));
    step(5);
    checks++; if (xq.size() !== 2 || xq[xq.size()-1].src !== 1'b1 || xq[xq.size()-1].evt.note !== 7'd67) begin
      errors++; $display("FAIL echo_after_live got %0d xfers want 2 ending echo note 67", xq.size());
    end
  endtask

  task automatic test_echo_off();
    int d0;
    xq.delete();
    d0 = drops;
    drive_echo(mk(1, 64, 50));
    step(5);
    drive_echo(mk(0, 62, 50));
    step(5);
    checks++; if (drops - d0 !== 1 || xq.size() !== 1) begin
      errors++; $display("FAIL echo_off_wrong got drops %0d xfers %0d want 1 and 1", drops - d0, xq.size());
    end
    drive_echo(mk(0, 64, 50));
    step(5);
    checks++; if (xq.size() !== 2 || xq[1].evt !== mk(0, 64, 50) || xq[1].src !== 1'b1) begin
      errors++; $display("FAIL echo_off_match got %0d xfers want 2 ending echo off note 64", xq.size());
    end
    // owner is NONE now, so a matching echo note-off must be discarded
    drive_echo(mk(0, 64, 51));
    step(5);
    checks++; if (drops - d0 !== 2 || xq.size() !== 2) begin
      errors++; $display("FAIL owner_none got drops %0d xfers %0d want 2 and 2", drops - d0, xq.size());
    end
  endtask

  task automatic test_en_freeze();
    xq.delete();
    bus.ch_ready = 1'b0;
    drive_live(mk(0, 40, 11));
    step(3);
    bus.en = 1'b0;
    bus.ch_ready = 1'b1;
    #1;
    checks++; if (bus.ch_trig !== 1'b0) begin errors++; $display("FAIL en_trig got %0b want 0", bus.ch_trig); end
    step(3);
    checks++; if (xq.size() !== 0 || bus.ch_note !== 7'd40) begin
      errors++; $display("FAIL en_hold got xfers %0d note %0d want 0 and 40", xq.size(), bus.ch_note);
    end
    bus.en = 1'b1;
    #1;
    checks++; if (bus.ch_trig !== 1'b1) begin errors++; $display("FAIL en_resume got %0b want 1", bus.ch_trig); end
    step(1);
    checks++; if (xq.size() !== 1) begin errors++; $display("FAIL en_xfer got %0d want 1", xq.size()); end
  endtask

  task automatic test_fifo_full();
    int d0;
    xq.delete();
    d0 = drops;
    bus.ch_ready = 1'b0;
    drive_live(mk(0, 41, 12));
    step(3);
    for (int i = 0; i < 5; i++) begin
      drive_echo(mk(1, 70 + i, 20));
      step(1);
    end
    step(2);
    checks++; if (drops - d0 !== 1 || xq.size() !== 0) begin
      errors++; $display("FAIL fifo_full got drops %0d xfers %0d want 1 and 0", drops - d0, xq.size());
    end
    bus.ch_ready = 1'b1;
    step(20);
    checks++; if (xq.size() !== 5) begin errors++; $display("FAIL fifo_drain got %0d want 5", xq.size()); end
    for (int i = 1; i < 5 && i < xq.size(); i++) begin
      checks++;
      if (xq[i].src !== 1'b1 || xq[i].evt.note !== 7'(69 + i) || xq[i].cyc - xq[i-1].cyc !== 2) begin
        errors++; $display("FAIL fifo_order[%0d] got src %0b note %0d gap %0d want 1 %0d 2",
                           i, xq[i].src, xq[i].evt.note, xq[i].cyc - xq[i-1].cyc, 69 + i);
      end
    end
  endtask

  task automatic test_simultaneous();
    xq.delete();
    drive_live(mk(0, 42, 13));
    drive_echo(mk(1, 80, 30));
    step(8);
    checks++; if (xq.size() !== 2) begin errors++; $display("FAIL simul_count got %0d want 2", xq.size()); end
    else begin
      checks++; if (xq[0].src !== 1'b0 || xq[0].evt.note !== 7'd42 || xq[1].src !== 1'b1 || xq[1].evt.note !== 7'd80) begin
        errors++; $display("FAIL simul_order got s%0b n%0d then s%0b n%0d want s0 n42 then s1 n80",
                           xq[0].src, xq[0].evt.note, xq[1].src, xq[1].evt.note);
      end
    end
  endtask

  task automatic test_reset_midsend();
    xq.delete();
    bus.ch_ready = 1'b0;
    drive_echo(mk(1, 81, 31));
    step(3);
    checks++; if (bus.ch_trig !== 1'b1) begin errors++; $display("FAIL midsend_pre got %0b want 1", bus.ch_trig); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({bus.ch_trig, bus.ch_note, bus.ch_src, bus.ch_pb} !== {1'b0, 7'd0, 1'b0, 9'd256}) begin
      errors++; $display("FAIL midsend_async got t%0b n%0d s%0b pb%0d want t0 n0 s0 pb256",
                         bus.ch_trig, bus.ch_note, bus.ch_src, bus.ch_pb);
    end
    drive_live(EVT_RESET);
    drive_echo(EVT_RESET);
    step(2);
    reset = 1'b0;
    bus.ch_ready = 1'b1;
    step(10);
    checks++; if (xq.size() !== 0) begin errors++; $display("FAIL midsend_after got %0d xfers want 0", xq.size()); end
  endtask

  // Event-level model: per step, live issues before echo; owner and last issued note gate echo events
  task automatic test_random();
    note_evt_t cap_l, cap_e, nl, ne, last_evt;
    xfer_t     exp_q[$];
    xfer_t     x;
    int        owner_m, exp_drops, d0;
    cap_l = EVT_RESET;
    cap_e = EVT_RESET;
    last_evt = EVT_RESET;
    owner_m = 0;
    for (int s = 0; s < 40; s++) begin
      nl = cap_l;
      ne = cap_e;
      if ($urandom_range(0, 1) == 1)
        nl = '{on: 1'($urandom_range(0, 1)), note: 7'(60 + 2 * $urandom_range(0, 2)), vel: 7'($urandom_range(0, 3)),
               pb: ($urandom_range(0, 1) == 1) ? PB_CENTER : 9'($urandom_range(0, 511)), cc1: 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        ne = '{on: 1'($urandom_range(0, 1)), note: 7'(60 + 2 * $urandom_range(0, 2)), vel: 7'($urandom_range(0, 3)),
               pb: ($urandom_range(0, 1) == 1) ? PB_CENTER : 9'($urandom_range(0, 511)), cc1: 2'($urandom_range(0, 3))};
      exp_q.delete();
      exp_drops = 0;
      if (nl != cap_l) begin
        x.evt = nl; x.src = 1'b0; x.cyc = 0;
        exp_q.push_back(x);
        owner_m = nl.on ? 1 : 0;
        last_evt = nl;
      end
      if (ne != cap_e) begin
        if (owner_m != 1 && (ne.on || (owner_m == 2 && ne.note == last_evt.note))) begin
          x.evt = ne; x.src = 1'b1; x.cyc = 0;
          exp_q.push_back(x);
          owner_m = ne.on ? 2 : 0;
          last_evt = ne;
        end else begin
          exp_drops++;
        end
      end
      cap_l = nl;
      cap_e = ne;
      xq.delete();
      d0 = drops;
      drive_live(nl);
      drive_echo(ne);
      for (int c = 0; c < 16; c++) begin
        bus.ch_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
      bus.ch_ready = 1'b1;
      step(8);
      checks++;
      if (xq.size() !== exp_q.size() || drops - d0 !== exp_drops) begin
        errors++; $display("FAIL rand_count[%0d] got xfers %0d drops %0d want %0d %0d",
                           s, xq.size(), drops - d0, exp_q.size(), exp_drops);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (xq[i].evt !== exp_q[i].evt || xq[i].src !== exp_q[i].src) begin
            errors++; $display("FAIL rand_xfer[%0d.%0d] got %h src %0b want %h src %0b",
                               s, i, xq[i].evt, xq[i].src, exp_q[i].evt, exp_q[i].src);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_live_basic();
    test_echo_blocked();
    test_echo_off();
    test_en_freeze();
    test_fifo_full();
    test_simultaneous();
    test_reset_midsend();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/echo_voice_arb.md
# echo_voice_arb

Sink for the echo generator's delayed event stream. It detects changes on the live note bundle and on the echo bundle, queues echo events, and arbitrates both onto a single Game Boy voice channel through a valid/ready trigger handshake. The live source always takes priority over the echo source. It sits between the MIDI note decoder and echo generator outputs on one side and the channel register writer on the other.

## Interface
- DEPTH, 4: echo event FIFO depth; power of two, ≥2.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  clock enable; 0 freezes all state and forces ch_trig=0.
- live_on / live_note / live_vel / live_pb / live_cc1  in  1/7/7/9/2  live note bundle (level).
- echo_on / echo_note / echo_vel / echo_pb / echo_cc1  in  1/7/7/9/2  echo bundle from the echo generator (level).
- ch_ready  in  1  channel writer can accept an event.
- ch_trig  out  1  event valid; held until accepted.
- ch_on / ch_note / ch_vel / ch_pb / ch_cc1  out  1/7/7/9/2  event payload; stable while ch_trig=1.
- ch_src  out  1  0 = live, 1 = echo.
- echo_drop  out  1  one-cycle pulse per echo event lost or discarded.

## Operation
- Change detection: each bundle is compared with its last-captured copy. Any field difference captures the new bundle that same edge and raises an event.
- Reset capture values: on=0, note=0, vel=0, pb=PB_CENTER (256), cc1=0.
- Live event: written to a single pending slot. A newer live event overwrites an unissued one; overwriting does not pulse echo_drop.
- Echo event: pushed into the FIFO. If the FIFO is full and no pop occurs that cycle, the new event is dropped and echo_drop pulses. Push and pop in the same cycle at full is legal and drops nothing.
- Owner register: NONE, LIVE or ECHO. It records which source last sounded a note.
- FSM IDLE:
  - If the live slot is pending: latch it to ch_*, set ch_src=0, clear the slot, go to SEND.
  - Otherwise, if the FIFO is non-empty, pop its head and apply these rules:
    - Owner=LIVE: discard the event and pulse echo_drop.
    - on=1: issue it with ch_src=1 and go to SEND.
    - on=0: issue only if owner=ECHO and the note equals ch_note. Otherwise discard and pulse echo_drop.
- FSM SEND: ch_trig=1. On ch_trig&&ch_ready, go to IDLE and update owner:
  - on=1 → owner = source.
  - on=0 → owner = NONE.
- Arithmetic: none beyond FIFO pointers (log2(DEPTH)+1 bits, wrap naturally).

## Timing
- Reset values: ch_trig=0, ch_on=0, ch_note=0, ch_vel=0, ch_pb=256, ch_cc1=0, ch_src=0, echo_drop=0. FSM=IDLE, owner=NONE, FIFO empty, pending clear.
- Latency: an input change sampled at edge k is captured at edge k. ch_trig rises after edge k+1 and transfers at the first edge with ch_ready=1.
- Back-to-back: one event per 2 cycles (SEND→IDLE→SEND).
- Simultaneous live and echo changes: both are captured; live issues first and echo follows.
- A live event arriving during SEND does not disturb the latched payload; it issues next.
- en=0 mid-SEND: ch_trig drops and the payload is held. ch_trig reasserts when en returns, with no transfer counted while en=0.
- Asynchronous reset mid-SEND: outputs go to reset values immediately and the in-flight event is lost.

## Structure
- Package echo_pkg:
  - note_evt_t packed struct {on, note[6:0], vel[6:0], pb[8:0], cc1[1:0]}, 26 bits.
  - PB_CENTER = 9'd256.
  - owner_t {OWN_NONE, OWN_LIVE, OWN_ECHO}.
  - arb_state_t {ST_IDLE, ST_SEND}.
- Sub-module note_evt_fifo: synchronous FIFO of note_evt_t, parameter DEPTH, with push/pop/full/empty.
- Change detectors, pending slot and FSM live in the top.

## Test plan
- Reset, ch_ready=1, live_on=1 note=60 vel=100 → ch_trig high 2 cycles later with ch_note=60, ch_vel=100, ch_src=0; accepted in 1 cycle.
- Live note 60 held, then echo_on=1 note=64 → echo_drop pulses once and no ch_trig. After live_on=0 (issued), a further echo note 67 on → issued with ch_src=1.
- Echo on 64 issued, then echo off with note 62 → discarded with echo_drop. Echo off with note 64 → issued and owner returns to NONE.
- ch_ready=0, five echo changes with DEPTH=4 → exactly one echo_drop on the 5th. Raise ch_ready → four events out in order, 2 cycles apart.
- Live and echo change on the same edge → live event transfers first, echo event on the next transfer.
- Assert reset while ch_trig=1 and ch_ready=0 → all outputs at reset values asynchronously; after release, no event without a new input change.
